// File: rtl/axi_dw_allocator_if.sv
// axi_dw_allocator_if: W-channel fan-in bus and AW ID push port of the W allocator
interface axi_dw_allocator_if #(
  parameter int AXI_DATA_W  = 64,
  parameter int AXI_USER_W  = 6,
  parameter int N_TARG_PORT = 7,
  parameter int LOG_N_TARG  = $clog2(N_TARG_PORT)
);
  logic [N_TARG_PORT-1:0][AXI_DATA_W-1:0]   wdata_i;
  logic [N_TARG_PORT-1:0][AXI_DATA_W/8-1:0] wstrb_i;
  logic [N_TARG_PORT-1:0]                   wlast_i;
  logic [N_TARG_PORT-1:0][AXI_USER_W-1:0]   wuser_i;
  logic [N_TARG_PORT-1:0]                   wvalid_i;
  logic [N_TARG_PORT-1:0]                   wready_o;
  logic [AXI_DATA_W-1:0]                    wdata_o;
  logic [AXI_DATA_W/8-1:0]                  wstrb_o;
  logic                                     wlast_o;
  logic [AXI_USER_W-1:0]                    wuser_o;
  logic                                     wvalid_o;
  logic                                     wready_i;
  logic                                     push_ID_i;
  logic [LOG_N_TARG+N_TARG_PORT-1:0]        ID_i;
  logic                                     grant_FIFO_ID_o;
  modport slave (
    input  wdata_i, wstrb_i, wlast_i, wuser_i, wvalid_i, wready_i, push_ID_i, ID_i,
    output wready_o, wdata_o, wstrb_o, wlast_o, wuser_o, wvalid_o, grant_FIFO_ID_o
  );
  modport master (
    output wdata_i, wstrb_i, wlast_i, wuser_i, wvalid_i, wready_i, push_ID_i, ID_i,
    input  wready_o, wdata_o, wstrb_o, wlast_o, wuser_o, wvalid_o, grant_FIFO_ID_o
  );
endinterface

// File: rtl/axi_dw_allocator.sv
// axi_dw_allocator: routes W bursts to the master port in the order their AWs were granted
module axi_dw_allocator #(
  parameter int AXI_DATA_W  = 64,
  parameter int AXI_USER_W  = 6,
  parameter int N_TARG_PORT = 7,
  parameter int LOG_N_TARG  = $clog2(N_TARG_PORT),
  parameter int FIFO_DEPTH  = 8
) (
  input logic               clk,
  input logic               rst,
  axi_dw_allocator_if.slave bus
);
  localparam int ID_W  = LOG_N_TARG + N_TARG_PORT;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  logic [ID_W-1:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [CNT_W-1:0]       count;
  logic [ID_W-1:0]        head;
  logic [LOG_N_TARG-1:0]  bin;
  logic [N_TARG_PORT-1:0] oh;
  logic                   sel, push, pop;
  assign head = mem[rd_ptr];
  assign bin  = head[ID_W-1:N_TARG_PORT];
  assign oh   = head[N_TARG_PORT-1:0];
  assign sel  = count != '0;
  assign bus.grant_FIFO_ID_o = count != CNT_W'(FIFO_DEPTH);
  assign push = bus.push_ID_i & bus.grant_FIFO_ID_o;
  assign pop  = bus.wvalid_o & bus.wready_i & bus.wlast_o;
  // Head is a registered FIFO entry, so a freshly pushed ID only routes from the next cycle.
  always_comb begin
    bus.wvalid_o = sel ? bus.wvalid_i[bin] : 1'b0;
    bus.wdata_o  = sel ? bus.wdata_i[bin]  : '0;
    bus.wstrb_o  = sel ? bus.wstrb_i[bin]  : '0;
    bus.wlast_o  = sel ? bus.wlast_i[bin]  : 1'b0;
    bus.wuser_o  = sel ? bus.wuser_i[bin]  : '0;
    bus.wready_o = sel ? (oh & {N_TARG_PORT{bus.wready_i}}) : '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.ID_i;
  end
endmodule

// File: tb/tb_axi_dw_allocator.sv
// tb_axi_dw_allocator: directed scenarios for the W allocator
module tb_axi_dw_allocator;
  localparam int N = 7;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  axi_dw_allocator_if #(.AXI_DATA_W(64), .AXI_USER_W(6), .N_TARG_PORT(N)) bus ();
  axi_dw_allocator #(.AXI_DATA_W(64), .AXI_USER_W(6), .N_TARG_PORT(N), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  always #5 clk = ~clk;
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end
  function automatic logic [63:0] dat(input int p, input int b);
    return {8'(p), 24'h5A5A5A, 32'(b)};
  endfunction
  function automatic logic [9:0] idv(input int p);
    return {3'(p), 7'(1 << p)};
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle;
    bus.wvalid_i = '0;
    bus.wlast_i = '0;
    bus.wdata_i = '0;
    bus.wstrb_i = '0;
    bus.wuser_i = '0;
    bus.push_ID_i = 1'b0;
    bus.ID_i = '0;
  endtask
  task automatic push(input int p);
    bus.push_ID_i = 1'b1;
    bus.ID_i = idv(p);
    tick;
    bus.push_ID_i = 1'b0;
  endtask
  task automatic drive_beat(input int p, input int b, input logic last);
    bus.wvalid_i[p] = 1'b1;
    bus.wdata_i[p] = dat(p, b);
    bus.wstrb_i[p] = 8'(p * 16 + b);
    bus.wuser_i[p] = 6'(p * 4 + b);
    bus.wlast_i[p] = last;
  endtask
  task automatic test_reset;
    idle;
    bus.wready_i = 1'b0;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    checks++; if (bus.grant_FIFO_ID_o !== 1'b1 || dut.count !== 4'd0) begin errors++; $display("FAIL reset_state: grant=%b count=%0d want grant=1 count=0", bus.grant_FIFO_ID_o, dut.count); end
    checks++; if (bus.wvalid_o !== 1'b0 || bus.wready_o !== 7'd0 || bus.wdata_o !== 64'd0) begin errors++; $display("FAIL reset_outputs: wvalid=%b wready=%b wdata=%h want 0", bus.wvalid_o, bus.wready_o, bus.wdata_o); end
    push(2);
    drive_beat(2, 0, 1'b0);
    bus.wready_i = 1'b1;
    #1;
    checks++; if (bus.wvalid_o !== 1'b1 || bus.wready_o !== 7'b0000100) begin errors++; $display("FAIL reset_pre_activity: wvalid=%b wready=%b want 1 0000100", bus.wvalid_o, bus.wready_o); end
    #1 rst = 1'b1;
    #1;
    checks++; if (bus.wvalid_o !== 1'b0 || bus.wready_o !== 7'd0 || bus.grant_FIFO_ID_o !== 1'b1 || dut.count !== 4'd0) begin errors++; $display("FAIL reset_async: wvalid=%b wready=%b grant=%b count=%0d want 0 0 1 0", bus.wvalid_o, bus.wready_o, bus.grant_FIFO_ID_o, dut.count); end
    tick;
    checks++; if (bus.wvalid_o !== 1'b0 || bus.wready_o !== 7'd0 || bus.grant_FIFO_ID_o !== 1'b1 || dut.count !== 4'd0) begin errors++; $display("FAIL reset_edge: wvalid=%b wready=%b grant=%b count=%0d want 0 0 1 0", bus.wvalid_o, bus.wready_o, bus.grant_FIFO_ID_o, dut.count); end
    rst = 1'b0;
    idle;
    tick;
  endtask
  task automatic test_single_burst;
    push(2);
    bus.wready_i = 1'b1;
    for (int b = 0; b < 4; b++) begin
      drive_beat(2, b, b == 3);
      #1;
      checks++; if (bus.wvalid_o !== 1'b1 || bus.wdata_o !== dat(2, b)) begin errors++; $display("FAIL single_data beat %0d: wvalid=%b wdata=%h want 1 %h", b, bus.wvalid_o, bus.wdata_o, dat(2, b)); end
      checks++; if (bus.wready_o !== 7'b0000100 || bus.wlast_o !== (b == 3)) begin errors++; $display("FAIL single_ready beat %0d: wready=%b wlast=%b want 0000100 %b", b, bus.wready_o, bus.wlast_o, b == 3); end
      checks++; if (bus.wstrb_o !== 8'(32 + b) || bus.wuser_o !== 6'(8 + b)) begin errors++; $display("FAIL single_sideband beat %0d: wstrb=%h wuser=%h want %h %h", b, bus.wstrb_o, bus.wuser_o, 8'(32 + b), 6'(8 + b)); end
      tick;
    end
    idle;
    #1;
    checks++; if (dut.count !== 4'd0 || bus.wvalid_o !== 1'b0 || bus.wready_o !== 7'd0 || bus.wdata_o !== 64'd0) begin errors++; $display("FAIL single_empty: count=%0d wvalid=%b wready=%b wdata=%h want all 0", dut.count, bus.wvalid_o, bus.wready_o, bus.wdata_o); end
  endtask
  task automatic test_back_to_back;
    int ep[6] = '{5, 5, 0, 0, 5, 5};
    int eb[6] = '{0, 1, 0, 1, 2, 3};
    int pb[N];
    for (int p = 0; p < N; p++) pb[p] = 0;
    push(5);
    push(0);
    push(5);
    bus.wready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      for (int p = 0; p < N; p++) drive_beat(p, pb[p], pb[p] % 2 == 1);
      #1;
      checks++; if (bus.wvalid_o !== 1'b1 || bus.wdata_o !== dat(ep[i], eb[i])) begin errors++; $display("FAIL b2b_data slot %0d: wvalid=%b wdata=%h want 1 %h", i, bus.wvalid_o, bus.wdata_o, dat(ep[i], eb[i])); end
      checks++; if (bus.wready_o !== 7'(1 << ep[i])) begin errors++; $display("FAIL b2b_ready slot %0d: wready=%b want %b", i, bus.wready_o, 7'(1 << ep[i])); end
      for (int p = 0; p < N; p++) if (bus.wready_o[p]) pb[p]++;
      tick;
    end
    idle;
    #1;
    checks++; if (dut.count !== 4'd0) begin errors++; $display("FAIL b2b_drained: count=%0d want 0", dut.count); end
  endtask
  task automatic test_full;
    int order[8] = '{0, 1, 2, 3, 4, 5, 6, 1};
    bus.wready_i = 1'b1;
    for (int i = 0; i < 8; i++) push(order[i]);
    checks++; if (bus.grant_FIFO_ID_o !== 1'b0 || dut.count !== 4'd8) begin errors++; $display("FAIL full_grant: grant=%b count=%0d want 0 8", bus.grant_FIFO_ID_o, dut.count); end
    push(3);
    checks++; if (bus.grant_FIFO_ID_o !== 1'b0 || dut.count !== 4'd8) begin errors++; $display("FAIL full_ignore: grant=%b count=%0d want 0 8", bus.grant_FIFO_ID_o, dut.count); end
    for (int i = 0; i < 8; i++) begin
      drive_beat(order[i], 0, 1'b1);
      #1;
      checks++; if (bus.wvalid_o !== 1'b1 || bus.wready_o !== 7'(1 << order[i])) begin errors++; $display("FAIL full_order entry %0d: wvalid=%b wready=%b want 1 %b", i, bus.wvalid_o, bus.wready_o, 7'(1 << order[i])); end
      tick;
      idle;
      if (i == 0) begin
        checks++; if (bus.grant_FIFO_ID_o !== 1'b1 || dut.count !== 4'd7) begin errors++; $display("FAIL full_release: grant=%b count=%0d want 1 7", bus.grant_FIFO_ID_o, dut.count); end
      end
    end
    checks++; if (dut.count !== 4'd0) begin errors++; $display("FAIL full_drained: count=%0d want 0", dut.count); end
  endtask
  task automatic test_backpressure;
    push(4);
    bus.wready_i = 1'b1;
    drive_beat(4, 0, 1'b0);
    tick;
    drive_beat(4, 1, 1'b0);
    bus.wready_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (bus.wready_o !== 7'd0 || bus.wvalid_o !== 1'b1 || bus.wdata_o !== dat(4, 1)) begin errors++; $display("FAIL bp_hold cycle %0d: wready=%b wvalid=%b wdata=%h want 0 1 %h", c, bus.wready_o, bus.wvalid_o, bus.wdata_o, dat(4, 1)); end
      tick;
      checks++; if (dut.count !== 4'd1) begin errors++; $display("FAIL bp_count cycle %0d: count=%0d want 1", c, dut.count); end
    end
    bus.wready_i = 1'b1;
    for (int b = 1; b < 4; b++) begin
      drive_beat(4, b, b == 3);
      #1;
      checks++; if (bus.wdata_o !== dat(4, b) || bus.wready_o !== 7'b0010000) begin errors++; $display("FAIL bp_resume beat %0d: wdata=%h wready=%b want %h 0010000", b, bus.wdata_o, bus.wready_o, dat(4, b)); end
      tick;
    end
    idle;
    checks++; if (dut.count !== 4'd0) begin errors++; $display("FAIL bp_drained: count=%0d want 0", dut.count); end
  endtask
  task automatic test_push_pop;
    int order[3] = '{6, 2, 3};
    bus.wready_i = 1'b1;
    push(1);
    push(6);
    push(2);
    bus.push_ID_i = 1'b1;
    bus.ID_i = idv(3);
    drive_beat(1, 0, 1'b1);
    #1;
    checks++; if (bus.wready_o !== 7'b0000010) begin errors++; $display("FAIL pp_ready: wready=%b want 0000010", bus.wready_o); end
    tick;
    idle;
    checks++; if (dut.count !== 4'd3) begin errors++; $display("FAIL pp_count: count=%0d want 3", dut.count); end
    for (int i = 0; i < 3; i++) begin
      drive_beat(order[i], 0, 1'b1);
      #1;
      checks++; if (bus.wready_o !== 7'(1 << order[i])) begin errors++; $display("FAIL pp_order entry %0d: wready=%b want %b", i, bus.wready_o, 7'(1 << order[i])); end
      tick;
      idle;
    end
    drive_beat(5, 0, 1'b1);
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++; if (bus.wvalid_o !== 1'b0 || bus.wready_o !== 7'd0) begin errors++; $display("FAIL early_w_stall cycle %0d: wvalid=%b wready=%b want 0 0", c, bus.wvalid_o, bus.wready_o); end
      tick;
    end
    bus.push_ID_i = 1'b1;
    bus.ID_i = idv(5);
    #1;
    checks++; if (bus.wvalid_o !== 1'b0 || bus.wready_o !== 7'd0) begin errors++; $display("FAIL early_w_nofall: wvalid=%b wready=%b want 0 0", bus.wvalid_o, bus.wready_o); end
    tick;
    bus.push_ID_i = 1'b0;
    #1;
    checks++; if (bus.wvalid_o !== 1'b1 || bus.wready_o !== 7'b0100000 || bus.wdata_o !== dat(5, 0)) begin errors++; $display("FAIL early_w_route: wvalid=%b wready=%b wdata=%h want 1 0100000 %h", bus.wvalid_o, bus.wready_o, bus.wdata_o, dat(5, 0)); end
    tick;
    idle;
    checks++; if (dut.count !== 4'd0) begin errors++; $display("FAIL early_w_drained: count=%0d want 0", dut.count); end
  endtask
  initial begin
    idle;
    bus.wready_i = 1'b0;
    test_reset;
    test_single_burst;
    test_back_to_back;
    test_full;
    test_backpressure;
    test_push_pop;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
